// File: rtl/lsu_pkg.sv
// LSU memory master shared definitions.
// Access codes and controller state encoding.
package lsu_pkg;

  localparam logic [2:0] M_LB  = 3'd0;
  localparam logic [2:0] M_LH  = 3'd1;
  localparam logic [2:0] M_LW  = 3'd2;
  localparam logic [2:0] M_LBU = 3'd4;
  localparam logic [2:0] M_LHU = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    ADDR0,
    RESP0,
    ADDR1,
    RESP1,
    DONE
  } state_t;

  function automatic logic illegal_op(
    input logic [2:0] op,
    input logic       we
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      (op == M_LB),
      (op == M_LH),
      (op == M_LW):  bad = 1'b0;
      (op == M_LBU),
      (op == M_LHU): bad = we;
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store mask/data placement and
// load data extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  op,
  input  logic [31:0] wdata,
  input  logic [31:0] rd0,
  input  logic [31:0] rd1,
  output logic [7:0]  mask,
  output logic [63:0] wide,
  output logic [31:0] rdata
);

  logic [3:0]  smask;
  logic [31:0] sh;

  always_comb begin
    smask = 4'b0001;
    unique case (op[1:0])
      2'd0:    smask = 4'b0001;
      2'd1:    smask = 4'b0011;
      default: smask = 4'b1111;
    endcase
  end

  assign mask = {4'b0000, smask} << off;
  assign wide = {32'd0, wdata} << {off, 3'b000};
  assign sh   = 32'({rd1, rd0} >> {off, 3'b000});

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (op == M_LB):  rdata = {{24{sh[7]}}, sh[7:0]};
      (op == M_LH):  rdata = {{16{sh[15]}}, sh[15:0]};
      (op == M_LW):  rdata = sh;
      (op == M_LBU): rdata = {24'd0, sh[7:0]};
      (op == M_LHU): rdata = {16'd0, sh[15:0]};
      default:       rdata = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit memory master: splits misaligned
// accesses into up to two word beats, one outstanding.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqWdata,
  input  logic [2:0]        reqMemOp,
  input  logic              reqWe,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspRdata,
  output logic              rspErr,
  output logic              memValid,
  input  logic              memReady,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memWe,
  output logic [3:0]        memWmask,
  output logic [DATA_W-1:0] memWdata,
  input  logic              memRvalid,
  input  logic [DATA_W-1:0] memRdata
);

  state_t state, state_n;

  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_wdata;
  logic [2:0]        a_op;
  logic              a_we;
  logic              a_err;
  logic [31:0]       rd0;
  logic [31:0]       rd1;

  logic              accept;
  logic              cap0;
  logic              cap1;
  logic              need2;
  logic [7:0]        mask;
  logic [63:0]       wide;
  logic [31:0]       ld;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] base1;

  lsu_align u_align (
    .off   (a_addr[1:0]),
    .op    (a_op),
    .wdata (a_wdata),
    .rd0   (rd0),
    .rd1   (rd1),
    .mask  (mask),
    .wide  (wide),
    .rdata (ld)
  );

  assign base   = {a_addr[ADDR_W-1:2], 2'b00};
  assign base1  = base + ADDR_W'(4);
  assign need2  = |mask[7:4];
  assign accept = (state == IDLE) && reqValid && rstn;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      a_addr  <= '0;
      a_wdata <= '0;
      a_op    <= '0;
      a_we    <= 1'b0;
      a_err   <= 1'b0;
      rd0     <= '0;
      rd1     <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_addr  <= reqAddr;
        a_wdata <= reqWdata;
        a_op    <= reqMemOp;
        a_we    <= reqWe;
        a_err   <= illegal_op(reqMemOp, reqWe);
        rd0     <= '0;
        rd1     <= '0;
      end
      if (cap0) rd0 <= memRdata;
      if (cap1) rd1 <= memRdata;
    end
  end

  always_comb begin
    state_n  = state;
    reqReady = 1'b0;
    rspValid = 1'b0;
    rspErr   = 1'b0;
    rspRdata = '0;
    memValid = 1'b0;
    memAddr  = '0;
    memWe    = 1'b0;
    memWmask = '0;
    memWdata = '0;
    cap0     = 1'b0;
    cap1     = 1'b0;
    unique case (state)
      IDLE: begin
        reqReady = rstn;
        if (accept)
          state_n = illegal_op(reqMemOp, reqWe) ? DONE : ADDR0;
      end
      ADDR0: begin
        memValid = 1'b1;
        memAddr  = base;
        memWe    = a_we;
        memWmask = mask[3:0];
        memWdata = wide[31:0];
        if (memReady) begin
          if (!a_we)      state_n = RESP0;
          else if (need2) state_n = ADDR1;
          else            state_n = DONE;
        end
      end
      RESP0: begin
        if (memRvalid) begin
          cap0    = 1'b1;
          state_n = need2 ? ADDR1 : DONE;
        end
      end
      ADDR1: begin
        memValid = 1'b1;
        memAddr  = base1;
        memWe    = a_we;
        memWmask = mask[7:4];
        memWdata = wide[63:32];
        if (memReady)
          state_n = a_we ? DONE : RESP1;
      end
      RESP1: begin
        if (memRvalid) begin
          cap1    = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        rspValid = 1'b1;
        rspErr   = a_err;
        rspRdata = (a_err || a_we) ? '0 : ld;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed
// accesses, a memory responder and a decoupled monitor.
module tb_lsu_mem_master;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic [2:0]  reqMemOp = '0;
  logic        reqWe = 1'b0;
  logic        rspValid;
  logic [31:0] rspRdata;
  logic        rspErr;
  logic        memValid;
  logic        memReady = 1'b1;
  logic [31:0] memAddr;
  logic        memWe;
  logic [3:0]  memWmask;
  logic [31:0] memWdata;
  logic        memRvalid = 1'b0;
  logic [31:0] memRdata = '0;

  beat_t        bq[$];
  rsp_t         eq[$];
  logic [31:0]  dq[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  logic         rv_pend = 1'b0;
  logic         hold_rv = 1'b0;
  logic         stray = 1'b0;

  lsu_mem_master dut (
    .clk       (clk),
    .rstn      (rstn),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqAddr   (reqAddr),
    .reqWdata  (reqWdata),
    .reqMemOp  (reqMemOp),
    .reqWe     (reqWe),
    .rspValid  (rspValid),
    .rspRdata  (rspRdata),
    .rspErr    (rspErr),
    .memValid  (memValid),
    .memReady  (memReady),
    .memAddr   (memAddr),
    .memWe     (memWe),
    .memWmask  (memWmask),
    .memWdata  (memWdata),
    .memRvalid (memRvalid),
    .memRdata  (memRdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Memory responder: read data one cycle after each read handshake.
  always @(negedge clk) begin
    if (!rstn) begin
      rv_pend = 1'b0;
      memRvalid = 1'b0;
    end else begin
      memRvalid = 1'b0;
      if (stray) begin
        memRvalid = 1'b1;
        memRdata = 32'h5A5A5A5A;
        stray = 1'b0;
      end else if (rv_pend) begin
        memRvalid = 1'b1;
        memRdata = (dq.size() > 0) ? dq.pop_front() : 32'hDEADBEEF;
        rv_pend = 1'b0;
      end
      if (memValid && memReady && !memWe && !hold_rv)
        rv_pend = 1'b1;
    end
  end

  // Monitor: compares every presented beat and response.
  always @(negedge clk) begin
    if (rstn) begin
      if (memValid) begin
        if (bq.size() == 0) begin
          total++; bad++;
          $display("FAIL beat_unexpected addr=%h exp=none", memAddr);
        end else begin
          chk("beat_addr", memAddr, bq[0].addr);
          chk("beat_we", 32'(memWe), 32'(bq[0].we));
          chk("beat_mask", 32'(memWmask), 32'(bq[0].mask));
          if (bq[0].we) chk("beat_wdata", memWdata, bq[0].data);
          if (memReady) void'(bq.pop_front());
        end
      end
      if (rspValid) begin
        if (eq.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected got=%h exp=none", rspRdata);
        end else begin
          chk("rsp_rdata", rspRdata, eq[0].rdata);
          chk("rsp_err", 32'(rspErr), 32'(eq[0].err));
          if (eq[0].lat >= 0)
            chk("rsp_lat", 32'(cyc - acc_cyc + 1), 32'(eq[0].lat));
          void'(eq.pop_front());
        end
      end
    end
  end

  task automatic chk_rst_outputs(input string tag);
    chk({tag, "_reqReady"}, 32'(reqReady), 32'd0);
    chk({tag, "_rspValid"}, 32'(rspValid), 32'd0);
    chk({tag, "_rspErr"}, 32'(rspErr), 32'd0);
    chk({tag, "_rspRdata"}, rspRdata, 32'd0);
    chk({tag, "_memValid"}, 32'(memValid), 32'd0);
    chk({tag, "_memWe"}, 32'(memWe), 32'd0);
    chk({tag, "_memWmask"}, 32'(memWmask), 32'd0);
    chk({tag, "_memAddr"}, memAddr, 32'd0);
    chk({tag, "_memWdata"}, memWdata, 32'd0);
  endtask

  task automatic beat(input logic [31:0] a, input logic we,
                      input logic [3:0] m, input logic [31:0] d);
    beat_t b;
    b.addr = a; b.we = we; b.mask = m; b.data = d;
    bq.push_back(b);
  endtask

  task automatic rsp(input logic [31:0] d, input logic e, input int lat);
    rsp_t r;
    r.rdata = d; r.err = e; r.lat = lat;
    eq.push_back(r);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] op, input logic we);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    reqValid = 1'b1; reqAddr = a; reqWdata = d;
    reqMemOp = op; reqWe = we;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (reqReady) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL req_accept_timeout got=0 exp=1");
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    reqValid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (bq.size() == 0 && eq.size() == 0) break;
      @(negedge clk);
    end
    if (bq.size() != 0 || eq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout got=%0d/%0d exp=0/0", bq.size(), eq.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #2;
    chk_rst_outputs("rst0");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(reqReady), 32'd1);

    beat(32'h100, 1'b0, 4'b1111, 32'h0);
    dq.push_back(32'h11223344);
    rsp(32'h11223344, 1'b0, 3);
    issue(32'h100, 32'h0, 3'd2, 1'b0); drain();

    beat(32'h200, 1'b0, 4'b1000, 32'h0);
    dq.push_back(32'h80000000);
    rsp(32'hFFFFFF80, 1'b0, 3);
    issue(32'h203, 32'h0, 3'd0, 1'b0); drain();

    beat(32'h200, 1'b0, 4'b1000, 32'h0);
    dq.push_back(32'h80000000);
    rsp(32'h00000080, 1'b0, 3);
    issue(32'h203, 32'h0, 3'd4, 1'b0); drain();

    beat(32'h100, 1'b1, 4'b1100, 32'hCCDD0000);
    beat(32'h104, 1'b1, 4'b0011, 32'h0000AABB);
    rsp(32'h0, 1'b0, 3);
    issue(32'h102, 32'hAABBCCDD, 3'd2, 1'b1); drain();

    beat(32'h100, 1'b1, 4'b1111, 32'h12345678);
    rsp(32'h0, 1'b0, 2);
    issue(32'h100, 32'h12345678, 3'd2, 1'b1); drain();

    beat(32'hFFFFFFFC, 1'b0, 4'b1000, 32'h0);
    beat(32'h00000000, 1'b0, 4'b0001, 32'h0);
    dq.push_back(32'hEE000000);
    dq.push_back(32'h000000FF);
    rsp(32'hFFFFFFEE, 1'b0, 5);
    issue(32'hFFFFFFFF, 32'h0, 3'd1, 1'b0); drain();

    rsp(32'h0, 1'b1, 1);
    issue(32'h100, 32'h0, 3'd6, 1'b0); drain();

    rsp(32'h0, 1'b1, 1);
    issue(32'h100, 32'h0, 3'd4, 1'b1); drain();

    beat(32'h200, 1'b1, 4'b0010, 32'h3456A500);
    rsp(32'h0, 1'b0, 2);
    issue(32'h201, 32'h123456A5, 3'd0, 1'b1); drain();

    beat(32'h100, 1'b1, 4'b1000, 32'hEF000000);
    beat(32'h104, 1'b1, 4'b0001, 32'h000000BE);
    rsp(32'h0, 1'b0, 3);
    issue(32'h103, 32'h0000BEEF, 3'd1, 1'b1); drain();

    // Stalled memory: beat must hold steady until accepted.
    memReady = 1'b0;
    beat(32'h100, 1'b0, 4'b1100, 32'h0);
    dq.push_back(32'h80010000);
    rsp(32'hFFFF8001, 1'b0, -1);
    issue(32'h102, 32'h0, 3'd1, 1'b0);
    repeat (3) @(posedge clk);
    #1 memReady = 1'b1;
    drain();

    // Reset while waiting for read data.
    hold_rv = 1'b1;
    beat(32'h300, 1'b0, 4'b1111, 32'h0);
    issue(32'h300, 32'h0, 3'd2, 1'b0);
    repeat (3) @(posedge clk);
    #3 rstn = 1'b0;
    #1 chk_rst_outputs("rst1");
    @(posedge clk); #1;
    hold_rv = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst1_ready", 32'(reqReady), 32'd1);
    @(posedge clk); #1 stray = 1'b1;
    repeat (4) @(negedge clk);
    chk("stray_ready", 32'(reqReady), 32'd1);

    beat(32'h104, 1'b0, 4'b1111, 32'h0);
    dq.push_back(32'hCAFEF00D);
    rsp(32'hCAFEF00D, 1'b0, 3);
    issue(32'h104, 32'h0, 3'd2, 1'b0); drain();

    chk("beat_q_empty", 32'(bq.size()), 32'd0);
    chk("rsp_q_empty", 32'(eq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_mem_master.md
LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; only 32 is supported.
REQ-003 SHALL have ports:
- clk  in  1  single clock; all logic on posedge.
- rstn  in  1  reset; asynchronous, active-low.
- reqValid  in  1  CPU request valid.
- reqReady  out  1  request accepted this cycle when reqValid is also 1.
- reqAddr  in  ADDR_W  byte address.
- reqWdata  in  32  store data, right-aligned.
- reqMemOp  in  3  access code: 0 = LB/SB, 1 = LH/SH, 2 = LW/SW, 4 = LBU, 5 = LHU.
- reqWe  in  1  1 = store, 0 = load.
- rspValid  out  1  one-cycle completion pulse.
- rspRdata  out  32  extended load data.
- rspErr  out  1  illegal request.
- memValid  out  1  memory beat request.
- memReady  in  1  memory accepts the beat.
- memAddr  out  ADDR_W  word-aligned address; bits [1:0] are 0.
- memWe  out  1  beat is a write.
- memWmask  out  4  byte enables, bit i = byte lane i.
- memWdata  out  32  lane-positioned write data.
- memRvalid  in  1  read data valid.
- memRdata  in  32  read word.

Function
REQ-004 SHALL implement FSM states IDLE, ADDR0, RESP0, ADDR1, RESP1, DONE.
REQ-005 SHALL assert reqReady only in IDLE and SHALL accept a request on reqValid&&reqReady, latching addr, wdata, memOp and we.
REQ-006 SHALL treat as illegal: memOp 3, 6 or 7; memOp 4 or 5 with reqWe=1. An illegal request goes IDLE->DONE with no memory beat, and DONE asserts rspErr=1 and rspRdata=0.
REQ-007 SHALL compute off = addr[1:0] and size mask smask (B = 0001, H = 0011, W = 1111). It SHALL form the 8-bit mask m = smask<<off and the 64-bit data d = wdata<<(8*off).
REQ-008 Beat 0 SHALL use word address addr&~3, mask m[3:0] and data d[31:0].
REQ-009 A second beat SHALL be issued iff m[7:4] != 0. It SHALL use word address (addr&~3)+4, modulo 2^ADDR_W, with mask m[7:4] and data d[63:32].
REQ-010 In ADDRn, memValid SHALL be 1, and memAddr, memWe, memWmask and memWdata SHALL be held stable until memValid&&memReady.
REQ-011 For loads, memWmask SHALL still indicate the read lanes, and memWe SHALL be 0.
REQ-012 After a store beat handshake, the FSM SHALL go to ADDR1 if a second beat is needed, otherwise to DONE; stores have no response phase.
REQ-013 After a load beat handshake, the FSM SHALL go to RESPn. It SHALL capture memRdata on memRvalid, then go to ADDR1 or DONE.
REQ-014 memRvalid outside RESP0/RESP1 SHALL be ignored.
REQ-015 Load data SHALL be ({rd1,rd0}>>(8*off)), truncated to the access size. It SHALL be sign-extended for LB/LH and zero-extended for LBU/LHU; LW is not extended. rd1 SHALL be 0 when only one beat is issued.
REQ-016 DONE SHALL last exactly one cycle with rspValid=1 and then return to IDLE; there is no response backpressure.
REQ-017 Aligned load with memReady=1 and memRvalid one cycle after the handshake: accept at T, handshake at T+1, data at T+2, rspValid at T+3.
REQ-018 Aligned store with memReady=1: accept at T, handshake at T+1, rspValid at T+2.
REQ-019 At most one memory beat SHALL be outstanding.

Reset
REQ-020 On rstn=0, the FSM SHALL go to IDLE immediately, abandoning any in-flight access, and SHALL NOT retry it.
REQ-021 During reset: reqReady=0, rspValid=0, rspErr=0, rspRdata=0, memValid=0, memWe=0, memWmask=0, memAddr=0, memWdata=0.
REQ-022 The first cycle after reset release SHALL be IDLE with reqReady=1.

Structure
REQ-023 Package lsu_pkg SHALL hold the memOp codes (M_LB=0, M_LH=1, M_LW=2, M_LBU=4, M_LHU=5; stores reuse 0/1/2) and the FSM state enum.
REQ-024 The lane shift, mask generation and extension SHALL live in one combinational sub-module, lsu_align.

Verification
REQ-025 LW addr 0x100, memRdata 0x11223344 -> one beat at 0x100, mask 1111, rspRdata 0x11223344 at T+3.
REQ-026 LB addr 0x203, memRdata 0x80000000 -> mask 1000, rspRdata 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-027 SW addr 0x102, data 0xAABBCCDD -> beat 0x100 mask 1100 data 0xCCDD0000, then beat 0x104 mask 0011 data 0x0000AABB.
REQ-028 LH addr 0xFFFFFFFF, rd0 0xEE000000, rd1 0x000000FF -> beats at 0xFFFFFFFC then 0x00000000, rspRdata 0xFFFFFFEE.
REQ-029 memOp 6, and separately LBU with reqWe=1 -> no memValid, rspValid with rspErr=1 one cycle after accept.
REQ-030 rstn low while waiting in RESP0 -> all outputs 0 at once; a later stray memRvalid is ignored; reqReady=1 after release.
